// File: rtl/branch_sequencer.sv
// branch_sequencer: 6502-style relative branch sequencing with NMOS timing
// (extra cycle when taken, one more when the target crosses a page).
module branch_sequencer #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        cond_sel,
   input  logic [7:0]        status,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              operand_valid,
   input  logic [7:0]        data_bus,
   output logic              operand_req,
   output logic              pc_we,
   output logic [ADDR_W-1:0] pc_next,
   output logic              busy,
   output logic              done,
   output logic              taken,
   output logic              page_cross
);
   typedef enum logic [2:0] {IDLE, OPERAND, ADD_LO, FIX_HI, DONE} state_t;
   localparam logic [ADDR_W-9:0] ONE_HI = 1;
   state_t r_state, w_state;
   logic [2:0] r_sel;
   logic [3:0] r_flags;
   logic [ADDR_W-1:0] r_pc, r_pcn, w_pcn;
   logic r_neg, r_cross, w_flag, w_cond, w_cross;
   logic r_req, r_we, r_busy, r_done, r_taken, r_pcross;
   logic w_req, w_we, w_busy, w_done, w_taken, w_pcross;
   logic [8:0] w_sum;
   logic [ADDR_W-9:0] w_hi;
   // r_flags keeps only the branch-relevant status bits: {N,V,Z,C}
   always_comb begin
      w_flag = r_sel[2] ? (r_sel[1] ? r_flags[1] : r_flags[0])
                        : (r_sel[1] ? r_flags[2] : r_flags[3]);
      w_cond = w_flag == r_sel[0];
      w_sum = {1'b0, r_pc[7:0]} + {1'b0, data_bus};
      w_cross = data_bus[7] ? ~w_sum[8] : w_sum[8];
      w_hi = r_neg ? r_pc[ADDR_W-1:8] - ONE_HI : r_pc[ADDR_W-1:8] + ONE_HI;
      w_state = r_state;
      w_req = 1'b0;
      w_we = 1'b0;
      w_pcn = r_pcn;
      w_busy = 1'b1;
      w_done = 1'b0;
      w_taken = r_taken;
      w_pcross = r_pcross;
      case (r_state)
         IDLE: begin
            w_busy = start;
            w_req = start;
            w_state = start ? OPERAND : IDLE;
         end
         OPERAND: begin
            w_req = ~operand_valid;
            if (operand_valid) begin
               w_state = w_cond ? ADD_LO : DONE;
               w_we = w_cond;
               w_pcn = w_cond ? {r_pc[ADDR_W-1:8], w_sum[7:0]} : r_pcn;
               w_done = ~w_cond;
               w_taken = w_cond;
               w_pcross = 1'b0;
            end
         end
         ADD_LO: begin
            w_state = r_cross ? FIX_HI : DONE;
            w_we = r_cross;
            w_pcn = r_cross ? {w_hi, r_pcn[7:0]} : r_pcn;
            w_done = ~r_cross;
            w_pcross = r_cross;
         end
         FIX_HI: begin
            w_state = DONE;
            w_done = 1'b1;
         end
         DONE: begin
            w_state = IDLE;
            w_busy = 1'b0;
         end
         default: begin
            w_state = IDLE;
            w_busy = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel <= '0;
         r_flags <= '0;
         r_pc <= '0;
         r_neg <= 1'b0;
         r_cross <= 1'b0;
         r_req <= 1'b0;
         r_we <= 1'b0;
         r_pcn <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_taken <= 1'b0;
         r_pcross <= 1'b0;
      end else begin
         r_state <= w_state;
         r_req <= w_req;
         r_we <= w_we;
         r_pcn <= w_pcn;
         r_busy <= w_busy;
         r_done <= w_done;
         r_taken <= w_taken;
         r_pcross <= w_pcross;
         if (r_state == IDLE && start) begin
            r_sel <= cond_sel;
            r_flags <= {status[7], status[6], status[1], status[0]};
            r_pc <= pc_in;
         end
         if (r_state == OPERAND && operand_valid) begin
            r_neg <= data_bus[7];
            r_cross <= w_cross;
         end
      end
   end
   assign operand_req = r_req;
   assign pc_we = r_we;
   assign pc_next = r_pcn;
   assign busy = r_busy;
   assign done = r_done;
   assign taken = r_taken;
   assign page_cross = r_pcross;
endmodule
